// File: rtl/dual_port_ram.sv
// True dual-port RAM, one clock, registered read data per port, read latency one cycle.
// No backpressure: both ports accept an access every cycle; port 0 wins a same-address write/write.
// Optional build macro DUAL_PORT_RAM_FWD_EN: cross-port read-during-write returns the new write data.
module dual_port_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs_0,
    input  logic                     oe_0,
    input  logic                     we_0,
    input  logic [ADDRESS_WIDTH-1:0] address_0,
    input  logic [DATA_WIDTH-1:0]    din_0,
    output logic [DATA_WIDTH-1:0]    dout_0,
    input  logic                     cs_1,
    input  logic                     oe_1,
    input  logic                     we_1,
    input  logic [ADDRESS_WIDTH-1:0] address_1,
    input  logic [DATA_WIDTH-1:0]    din_1,
    output logic [DATA_WIDTH-1:0]    dout_1,
    output logic                     collision
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_0;
    logic                  wr_1;
    logic                  rd_0;
    logic                  rd_1;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] rdata_0;
    logic [DATA_WIDTH-1:0] rdata_1;

    assign wr_0      = cs_0 & we_0;
    assign wr_1      = cs_1 & we_1;
    assign rd_0      = cs_0 & ~we_0 & oe_0;
    assign rd_1      = cs_1 & ~we_1 & oe_1;
    assign same_addr = (address_0 == address_1);

    // A reading port is never writing, so forwarding only ever takes the other port's din.
    always_comb begin
        rdata_0 = mem[address_0];
        rdata_1 = mem[address_1];
`ifdef DUAL_PORT_RAM_FWD_EN
        if (wr_1 && same_addr) begin
            rdata_0 = din_1;
        end
        if (wr_0 && same_addr) begin
            rdata_1 = din_0;
        end
`endif
    end

    // Storage is deliberately left untouched by reset; reset only blocks writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else begin
            if (wr_1 && !(wr_0 && same_addr)) begin
                mem[address_1] <= din_1;
            end
            if (wr_0) begin
                mem[address_0] <= din_0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_0    <= '0;
            dout_1    <= '0;
            collision <= 1'b0;
        end else begin
            if (rd_0) begin
                dout_0 <= rdata_0;
            end
            if (rd_1) begin
                dout_1 <= rdata_1;
            end
            collision <= wr_0 & wr_1 & same_addr;
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboarded bench for dual_port_ram: directed sequences plus randomized traffic against an array model.
module tb_dual_port_ram;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          cs_0, oe_0, we_0, cs_1, oe_1, we_1;
    logic [AW-1:0] address_0, address_1;
    logic [DW-1:0] din_0, din_1;
    logic [DW-1:0] dout_0, dout_1;
    logic          collision;

    dual_port_ram #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cs_0(cs_0), .oe_0(oe_0), .we_0(we_0), .address_0(address_0), .din_0(din_0), .dout_0(dout_0),
        .cs_1(cs_1), .oe_1(oe_1), .we_1(we_1), .address_1(address_1), .din_1(din_1), .dout_1(dout_1),
        .collision(collision)
    );

    typedef struct packed {
        logic [DW-1:0] val;
        logic          known;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t qc[$];

    // Reference: plain array of words plus a "has been written" flag per address.
    logic [DW-1:0] ref_mem [DEPTH];
    logic          ref_known [DEPTH];
    exp_t          e0, e1, ec;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        e0 = '{val: '0, known: 1'b1};
        e1 = '{val: '0, known: 1'b1};
        ec = '{val: '0, known: 1'b1};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0 = '{val: '0, known: 1'b1};
            e1 = '{val: '0, known: 1'b1};
            ec = '{val: '0, known: 1'b1};
        end else begin
            bit w0, w1, r0, r1, same;
            w0   = cs_0 && we_0;
            w1   = cs_1 && we_1;
            r0   = cs_0 && !we_0 && oe_0;
            r1   = cs_1 && !we_1 && oe_1;
            same = (address_0 == address_1);
            if (r0) e0 = '{val: ref_mem[address_0], known: ref_known[address_0]};
            if (r1) e1 = '{val: ref_mem[address_1], known: ref_known[address_1]};
`ifdef DUAL_PORT_RAM_FWD_EN
            if (r0 && w1 && same) e0 = '{val: din_1, known: 1'b1};
            if (r1 && w0 && same) e1 = '{val: din_0, known: 1'b1};
`endif
            if (w1) begin
                ref_mem[address_1]   = din_1;
                ref_known[address_1] = 1'b1;
            end
            if (w0) begin
                ref_mem[address_0]   = din_0;
                ref_known[address_0] = 1'b1;
            end
            ec = '{val: {{(DW-1){1'b0}}, (w0 && w1 && same)}, known: 1'b1};
            q0.push_back(e0);
            q1.push_back(e1);
            qc.push_back(ec);
        end
    end

    // Monitor: output registers update on posedge; compare on the following negedge.
    always @(negedge clk) begin
        exp_t e;
        while (q0.size() > 0) begin
            e = q0.pop_front();
            if (e.known) begin
                checks++;
                if (dout_0 !== e.val) begin
                    errors++;
                    $display("FAIL dout_0 t=%0t got %0d expected %0d", $time, dout_0, e.val);
                end
            end
        end
        while (q1.size() > 0) begin
            e = q1.pop_front();
            if (e.known) begin
                checks++;
                if (dout_1 !== e.val) begin
                    errors++;
                    $display("FAIL dout_1 t=%0t got %0d expected %0d", $time, dout_1, e.val);
                end
            end
        end
        while (qc.size() > 0) begin
            e = qc.pop_front();
            checks++;
            if (collision !== e.val[0]) begin
                errors++;
                $display("FAIL collision t=%0t got %0b expected %0b", $time, collision, e.val[0]);
            end
        end
    end

    task automatic drive(input logic c0, input logic o0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic c1, input logic o1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        cs_0 = c0; oe_0 = o0; we_0 = w0; address_0 = a0; din_0 = d0;
        cs_1 = c1; oe_1 = o1; we_1 = w1; address_1 = a1; din_1 = d1;
        @(posedge clk);
    endtask

    task automatic check_zero(input string name, input logic [DW-1:0] got);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL %s got %0d expected 0", name, got);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cs_0 = 0; oe_0 = 0; we_0 = 0; address_0 = '0; din_0 = '0;
        cs_1 = 0; oe_1 = 0; we_1 = 0; address_1 = '0; din_1 = '0;
        #12;
        check_zero("reset_dout_0", dout_0);
        check_zero("reset_dout_1", dout_1);
        check_zero("reset_collision", {7'd0, collision});
        @(negedge clk);
        rst_n = 1'b1;

        // Port 0 writes, then reads back on port 0 and port 1.
        drive(1,0,1,8'd0,8'd145, 0,0,0,8'd0,8'd0);
        drive(1,0,1,8'd1,8'd155, 0,0,0,8'd0,8'd0);
        drive(1,0,1,8'd2,8'd165, 0,0,0,8'd0,8'd0);
        drive(1,1,0,8'd0,8'd0,   1,1,0,8'd2,8'd0);
        drive(1,1,0,8'd1,8'd0,   1,1,0,8'd1,8'd0);
        drive(1,1,0,8'd2,8'd0,   1,1,0,8'd0,8'd0);
        // Non-write to address 3, then read it; gated reads/writes.
        drive(1,0,1,8'd3,8'd60,  0,0,0,8'd0,8'd0);
        drive(0,0,0,8'd0,8'd0,   1,0,0,8'd3,8'd175);
        drive(0,0,0,8'd0,8'd0,   1,1,0,8'd3,8'd0);
        drive(0,0,0,8'd0,8'd0,   1,0,0,8'd0,8'd0);
        drive(0,0,0,8'd0,8'd0,   0,1,0,8'd1,8'd0);
        drive(0,0,1,8'd0,8'd9,   1,1,0,8'd0,8'd0);
        // Boundary address and collision.
        drive(0,0,0,8'd0,8'd0,   1,0,1,8'd255,8'd77);
        drive(1,1,0,8'd255,8'd0, 0,0,0,8'd0,8'd0);
        drive(1,0,1,8'd5,8'hAA,  1,0,1,8'd5,8'h55);
        drive(1,1,0,8'd5,8'd0,   1,1,0,8'd5,8'd0);
        // Read-during-write on address 7.
        drive(1,0,1,8'd7,8'h11,  0,0,0,8'd0,8'd0);
        drive(1,0,1,8'd7,8'h22,  1,1,0,8'd7,8'd0);
        drive(0,0,0,8'd0,8'd0,   1,1,0,8'd7,8'd0);

        // Asynchronous reset pulse mid-cycle; memory contents survive.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_dout_0", dout_0);
        check_zero("async_dout_1", dout_1);
        check_zero("async_collision", {7'd0, collision});
        #1 rst_n = 1'b1;
        drive(1,1,0,8'd1,8'd0,   1,1,0,8'd7,8'd0);

        // Randomized traffic, mostly on a small window to provoke overlaps.
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a0, a1;
            a0 = ($urandom_range(0,7) == 0) ? AW'($urandom) : AW'($urandom_range(0,7));
            a1 = ($urandom_range(0,7) == 0) ? AW'($urandom) : AW'($urandom_range(0,7));
            drive(1'($urandom_range(0,4) != 0), 1'($urandom), 1'($urandom), a0, DW'($urandom),
                  1'($urandom_range(0,4) != 0), 1'($urandom), 1'($urandom), a1, DW'($urandom));
        end

        drive(0,0,0,8'd0,8'd0, 0,0,0,8'd0,8'd0);
        @(negedge clk);
        #1;
        checks++;
        if (q0.size() + q1.size() + qc.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q0.size() + q1.size() + qc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
